// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, parity selectors and the default
// character width. Used by both the transmit and the receive cores.
// Optional feature macro: UART_TX_BREAK_EN adds a sixth BREAK state.
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

`ifdef UART_TX_BREAK_EN
    localparam int STATE_W = 6;
`else
    localparam int STATE_W = 5;
`endif

    // One-hot transmit states; all-zero is never a legal state.
    typedef enum logic [STATE_W-1:0] {
        ST_INTERVAL  = STATE_W'(1),
        ST_STARTBIT  = STATE_W'(2),
        ST_DATABITS  = STATE_W'(4),
        ST_PARITYBIT = STATE_W'(8),
        ST_STOPBIT   = STATE_W'(16)
`ifdef UART_TX_BREAK_EN
        , ST_BREAK   = STATE_W'(32)
`endif
    } txState_e;

    // Turns the XOR of all data bits into the parity bit for the chosen method.
    function automatic logic parityFromXor(input logic dataXor, input logic method);
        return (method == PARITY_EVEN) ? dataXor : ~dataXor;
    endfunction

endpackage

// File: rtl/uart_tx_prefetch.sv
// One-byte holding register for the UART transmitter together with the Tx FIFO
// read handshake: a single-clk active-low read strobe, capture of the FIFO data
// on the clk after the strobe, and the full flag seen by the transmit FSM.
// At most one read is ever outstanding.
module uart_tx_prefetch
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p_Allow_i,
    input  logic                 p_Empty_i,
    input  logic [DATA_BITS-1:0] Data_i,
    input  logic                 p_Take_i,
    output logic                 n_Rd_o,
    output logic                 p_Full_o,
    output logic [DATA_BITS-1:0] HoldData_o
);

    logic                 rdStrobe_q, rdStrobe_d;
    logic                 rdWait_q,   rdWait_d;
    logic                 full_q,     full_d;
    logic [DATA_BITS-1:0] hold_q,     hold_d;

    // Read issue, capture one clk after the strobe, and release when the FSM takes the byte.
    always_comb begin
        rdStrobe_d = 1'b0;
        rdWait_d   = rdStrobe_q;
        full_d     = full_q;
        hold_d     = hold_q;

        if (rdWait_q) begin
            hold_d = Data_i;
            full_d = 1'b1;
        end else if (p_Take_i) begin
            full_d = 1'b0;
        end

        if (!full_q && !rdStrobe_q && !rdWait_q && !p_Empty_i && p_Allow_i) begin
            rdStrobe_d = 1'b1;
        end
    end

    // Handshake and holding register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdStrobe_q <= 1'b0;
            rdWait_q   <= 1'b0;
            full_q     <= 1'b0;
            hold_q     <= '0;
        end else begin
            rdStrobe_q <= rdStrobe_d;
            rdWait_q   <= rdWait_d;
            full_q     <= full_d;
            hold_q     <= hold_d;
        end
    end

    assign n_Rd_o     = ~rdStrobe_q;
    assign p_Full_o   = full_q;
    assign HoldData_o = hold_q;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises bytes from the Tx FIFO as start bit, data
// bits (LSB or MSB first), optional parity and one or two stop bits. A prefetch
// holding register lets consecutive characters leave with no idle bit.
// Optional feature macro: UART_TX_BREAK_EN adds p_Break_i and a BREAK state that
// holds the line low for BREAK_BITS bit-times followed by one high bit-time.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
`ifdef UART_TX_BREAK_EN
    , parameter int BREAK_BITS = 12
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p_Enable_i,
    input  logic                 BaudSig_i,
    input  logic [DATA_BITS-1:0] Data_i,
    input  logic                 p_Empty_i,
    output logic                 n_Rd_o,
    input  logic                 p_ParityEnable_i,
    input  logic                 ParityMethod_i,
    input  logic                 p_BigEnd_i,
    input  logic                 p_TwoStop_i,
`ifdef UART_TX_BREAK_EN
    input  logic                 p_Break_i,
`endif
    output logic                 Tx_o,
    output logic [STATE_W-1:0]   State_o,
    output logic                 p_Busy_o,
    output logic                 p_ByteSent_o,
    output logic [15:0]          TxByteCnt_o
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    txState_e             state_q,   state_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [CNT_W-1:0]     bitCnt_q,  bitCnt_d;
    logic                 parEn_q,   parEn_d;
    logic                 parBit_q,  parBit_d;
    logic                 bigEnd_q,  bigEnd_d;
    logic                 twoStop_q, twoStop_d;
    logic                 stopCnt_q, stopCnt_d;
    logic                 tx_q,      tx_d;
    logic                 sent_q,    sent_d;
    logic [15:0]          byteCnt_q, byteCnt_d;

    logic                 holdFull;
    logic [DATA_BITS-1:0] holdData;
    logic                 take;
    logic                 startChar;
    logic                 rdAllow;

`ifdef UART_TX_BREAK_EN
    localparam int BRK_W = $clog2(BREAK_BITS + 1);

    logic [BRK_W-1:0]     brkCnt_q,  brkCnt_d;
    logic                 brkPrev_q, brkPrev_d;
    logic                 brkPend_q, brkPend_d;

    assign rdAllow = p_Enable_i && (state_q != ST_BREAK) && !brkPend_q;
`else
    assign rdAllow = p_Enable_i;
`endif

    uart_tx_prefetch #(
        .DATA_BITS (DATA_BITS)
    ) u_prefetch (
        .clk        (clk),
        .rst        (rst),
        .p_Allow_i  (rdAllow),
        .p_Empty_i  (p_Empty_i),
        .Data_i     (Data_i),
        .p_Take_i   (take),
        .n_Rd_o     (n_Rd_o),
        .p_Full_o   (holdFull),
        .HoldData_o (holdData)
    );

    // Next-state and registered-output logic; everything moves only on a BaudSig_i clk.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitCnt_d  = bitCnt_q;
        parEn_d   = parEn_q;
        parBit_d  = parBit_q;
        bigEnd_d  = bigEnd_q;
        twoStop_d = twoStop_q;
        stopCnt_d = stopCnt_q;
        tx_d      = tx_q;
        sent_d    = 1'b0;
        byteCnt_d = byteCnt_q;
        take      = 1'b0;
        startChar = 1'b0;
`ifdef UART_TX_BREAK_EN
        brkCnt_d  = brkCnt_q;
        brkPrev_d = p_Break_i;
        brkPend_d = brkPend_q;
        if (p_Break_i && !brkPrev_q && (state_q == ST_INTERVAL)) begin
            brkPend_d = 1'b1;
        end
`endif

        if (BaudSig_i) begin
            case (state_q)
                ST_INTERVAL: begin
`ifdef UART_TX_BREAK_EN
                    if (brkPend_q) begin
                        state_d   = ST_BREAK;
                        tx_d      = 1'b0;
                        brkCnt_d  = '0;
                        brkPend_d = 1'b0;
                    end else
`endif
                    if (holdFull && p_Enable_i) begin
                        startChar = 1'b1;
                    end
                end

                ST_STARTBIT: begin
                    state_d  = ST_DATABITS;
                    tx_d     = bigEnd_q ? shift_q[DATA_BITS-1] : shift_q[0];
                    shift_d  = bigEnd_q ? (shift_q << 1) : (shift_q >> 1);
                    bitCnt_d = CNT_W'(1);
                end

                ST_DATABITS: begin
                    if (bitCnt_q == CNT_W'(DATA_BITS)) begin
                        if (parEn_q) begin
                            state_d = ST_PARITYBIT;
                            tx_d    = parBit_q;
                        end else begin
                            state_d   = ST_STOPBIT;
                            tx_d      = 1'b1;
                            stopCnt_d = 1'b0;
                        end
                    end else begin
                        tx_d     = bigEnd_q ? shift_q[DATA_BITS-1] : shift_q[0];
                        shift_d  = bigEnd_q ? (shift_q << 1) : (shift_q >> 1);
                        bitCnt_d = bitCnt_q + CNT_W'(1);
                    end
                end

                ST_PARITYBIT: begin
                    state_d   = ST_STOPBIT;
                    tx_d      = 1'b1;
                    stopCnt_d = 1'b0;
                end

                ST_STOPBIT: begin
                    if (twoStop_q && !stopCnt_q) begin
                        stopCnt_d = 1'b1;
                    end else begin
                        sent_d    = 1'b1;
                        byteCnt_d = byteCnt_q + 16'd1;
                        if (holdFull && p_Enable_i) begin
                            startChar = 1'b1;
                        end else begin
                            state_d = ST_INTERVAL;
                            tx_d    = 1'b1;
                        end
                    end
                end

`ifdef UART_TX_BREAK_EN
                ST_BREAK: begin
                    if (brkCnt_q == BRK_W'(BREAK_BITS)) begin
                        state_d = ST_INTERVAL;
                        tx_d    = 1'b1;
                    end else begin
                        brkCnt_d = brkCnt_q + BRK_W'(1);
                        if (brkCnt_q == BRK_W'(BREAK_BITS - 1)) begin
                            tx_d = 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state_d = ST_INTERVAL;
                    tx_d    = 1'b1;
                end
            endcase

            if (startChar) begin
                state_d   = ST_STARTBIT;
                tx_d      = 1'b0;
                take      = 1'b1;
                shift_d   = holdData;
                bitCnt_d  = '0;
                stopCnt_d = 1'b0;
                parEn_d   = p_ParityEnable_i;
                parBit_d  = parityFromXor(^holdData, ParityMethod_i);
                bigEnd_d  = p_BigEnd_i;
                twoStop_d = p_TwoStop_i;
            end
        end
    end

    // Transmit state registers; reset returns the line to idle high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INTERVAL;
            shift_q   <= '0;
            bitCnt_q  <= '0;
            parEn_q   <= 1'b0;
            parBit_q  <= 1'b0;
            bigEnd_q  <= 1'b0;
            twoStop_q <= 1'b0;
            stopCnt_q <= 1'b0;
            tx_q      <= 1'b1;
            sent_q    <= 1'b0;
            byteCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bitCnt_q  <= bitCnt_d;
            parEn_q   <= parEn_d;
            parBit_q  <= parBit_d;
            bigEnd_q  <= bigEnd_d;
            twoStop_q <= twoStop_d;
            stopCnt_q <= stopCnt_d;
            tx_q      <= tx_d;
            sent_q    <= sent_d;
            byteCnt_q <= byteCnt_d;
        end
    end

`ifdef UART_TX_BREAK_EN
    // Break request edge detector, pending flag and bit-time counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brkCnt_q  <= '0;
            brkPrev_q <= 1'b0;
            brkPend_q <= 1'b0;
        end else begin
            brkCnt_q  <= brkCnt_d;
            brkPrev_q <= brkPrev_d;
            brkPend_q <= brkPend_d;
        end
    end
`endif

    assign Tx_o         = tx_q;
    assign State_o      = state_q;
    assign p_Busy_o     = (state_q != ST_INTERVAL) || holdFull;
    assign p_ByteSent_o = sent_q;
    assign TxByteCnt_o  = byteCnt_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: table of characters with hand-derived
// frames, a FIFO model, a bit-level receiver scoreboard, and hand-written
// sequences for back-to-back, enable drop, mid-character reset and break.
module tb_uart_tx_engine;
    import uart_pkg::*;

    localparam logic [STATE_W-1:0] S_INTERVAL  = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_DATABITS  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_PARITYBIT = STATE_W'(8);
`ifdef UART_TX_BREAK_EN
    localparam logic [STATE_W-1:0] S_BREAK     = STATE_W'(32);
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               p_Enable_i;
    logic               BaudSig_i = 1'b0;
    logic [7:0]         Data_i = 8'h00;
    logic               p_Empty_i = 1'b1;
    logic               n_Rd_o;
    logic               p_ParityEnable_i;
    logic               ParityMethod_i;
    logic               p_BigEnd_i;
    logic               p_TwoStop_i;
`ifdef UART_TX_BREAK_EN
    logic               p_Break_i;
`endif
    logic               Tx_o;
    logic [STATE_W-1:0] State_o;
    logic               p_Busy_o;
    logic               p_ByteSent_o;
    logic [15:0]        TxByteCnt_o;

    uart_tx_engine dut (
        .clk              (clk),
        .rst              (rst),
        .p_Enable_i       (p_Enable_i),
        .BaudSig_i        (BaudSig_i),
        .Data_i           (Data_i),
        .p_Empty_i        (p_Empty_i),
        .n_Rd_o           (n_Rd_o),
        .p_ParityEnable_i (p_ParityEnable_i),
        .ParityMethod_i   (ParityMethod_i),
        .p_BigEnd_i       (p_BigEnd_i),
        .p_TwoStop_i      (p_TwoStop_i),
`ifdef UART_TX_BREAK_EN
        .p_Break_i        (p_Break_i),
`endif
        .Tx_o             (Tx_o),
        .State_o          (State_o),
        .p_Busy_o         (p_Busy_o),
        .p_ByteSent_o     (p_ByteSent_o),
        .TxByteCnt_o      (TxByteCnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        parEn;
        logic        parOdd;
        logic        bigEnd;
        logic        twoStop;
        logic [11:0] frame;
        int          len;
    } vec_t;

    typedef struct {
        logic [11:0] bits;
        int          len;
    } frame_t;

    vec_t        vecs[6];
    logic [7:0]  fifoQ[$];
    frame_t      expQ[$];
    int          gapQ[$];
    frame_t      popped;

    int          totalChecks = 0;
    int          badChecks = 0;
    bit          monOn = 1'b0;
    bit          rxActive = 1'b0;
    int          rxCnt = 0;
    int          rxLen = 0;
    logic [11:0] rxBits = '0;
    int          baudCnt = 0;
    int          sampleIdx = 0;
    int          lastEndIdx = 0;
    int          framesDone = 0;
    int          rdPulses = 0;
    int          rdWide = 0;
    int          sentPulses = 0;
    int          sentWide = 0;
    bit          prevRdLow = 1'b0;
    bit          prevSent = 1'b0;
    logic        lastSample = 1'b1;
    int          baudSeq = 0;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Frame model: start, data in the chosen order, parity from a ones count, stop bits.
    function automatic frame_t buildFrame(input logic [7:0] d, input logic parEn, input logic parOdd,
                                          input logic bigEnd, input logic twoStop);
        frame_t f;
        int     n;
        int     ones;
        f.bits = '0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            f.bits[11-n] = bigEnd ? d[7-i] : d[i];
            n++;
        end
        if (parEn) begin
            ones = $countones(d);
            f.bits[11-n] = parOdd ? ((ones % 2) == 0) : ((ones % 2) == 1);
            n++;
        end
        f.bits[11-n] = 1'b1;
        n++;
        if (twoStop) begin
            f.bits[11-n] = 1'b1;
            n++;
        end
        f.len = n;
        return f;
    endfunction

    // Line receiver scoreboard, baud generator and Tx FIFO model, all on the falling edge.
    always @(negedge clk) begin
        if (BaudSig_i) begin
            lastSample = Tx_o;
            baudSeq++;
            if (monOn) begin
                sampleIdx++;
                if (!rxActive) begin
                    if (Tx_o == 1'b0) begin
                        if (expQ.size() == 0) begin
                            checkOutput("unexpected start bit", 16'd1, 16'd0);
                        end else begin
                            rxActive = 1'b1;
                            rxLen    = expQ[0].len;
                            rxBits   = '0;
                            rxCnt    = 1;
                            gapQ.push_back(sampleIdx - lastEndIdx - 1);
                        end
                    end
                end else begin
                    rxBits[11-rxCnt] = Tx_o;
                    rxCnt++;
                    if (rxCnt == rxLen) begin
                        popped = expQ.pop_front();
                        checkOutput("frame bits", {4'h0, rxBits}, {4'h0, popped.bits});
                        framesDone++;
                        rxActive   = 1'b0;
                        lastEndIdx = sampleIdx;
                    end
                end
            end
        end

        baudCnt   = (baudCnt == 15) ? 0 : baudCnt + 1;
        BaudSig_i = (baudCnt == 15);

        if (!rst && (n_Rd_o == 1'b0)) begin
            rdPulses++;
            if (prevRdLow) rdWide++;
            if (fifoQ.size() > 0) Data_i = fifoQ.pop_front();
            else checkOutput("read while FIFO empty", 16'd1, 16'd0);
        end
        prevRdLow = (n_Rd_o == 1'b0);
        p_Empty_i = (fifoQ.size() == 0);

        if (p_ByteSent_o) begin
            sentPulses++;
            if (prevSent) sentWide++;
        end
        prevSent = p_ByteSent_o;
    end

    task automatic applyStimulus(input vec_t v);
        frame_t f;
        @(posedge clk);
        #1;
        p_ParityEnable_i = v.parEn;
        ParityMethod_i   = v.parOdd;
        p_BigEnd_i       = v.bigEnd;
        p_TwoStop_i      = v.twoStop;
        f.bits = v.frame;
        f.len  = v.len;
        expQ.push_back(f);
        fifoQ.push_back(v.data);
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (framesDone < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("frames received", 16'(framesDone), 16'(target));
    endtask

    function automatic vec_t randVec();
        vec_t   v;
        frame_t f;
        v.data    = 8'($urandom_range(0, 255));
        v.parEn   = 1'b0;
        v.parOdd  = 1'b0;
        v.bigEnd  = 1'b0;
        v.twoStop = 1'b0;
        f = buildFrame(v.data, v.parEn, v.parOdd, v.bigEnd, v.twoStop);
        v.frame = f.bits;
        v.len   = f.len;
        return v;
    endfunction

    initial begin
        int   base;
        int   rd0;
        int   n;
        vec_t v;

        rst              = 1'b1;
        p_Enable_i       = 1'b1;
        p_ParityEnable_i = 1'b0;
        ParityMethod_i   = PARITY_EVEN;
        p_BigEnd_i       = 1'b0;
        p_TwoStop_i      = 1'b0;
`ifdef UART_TX_BREAK_EN
        p_Break_i        = 1'b0;
`endif

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 12'b0101_0010_1100, 10};
        vecs[1] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 12'b0000_0001_1111, 12};
        vecs[2] = '{8'h5C, 1'b1, 1'b0, 1'b0, 1'b0, 12'b0001_1101_0010, 11};
        vecs[3] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 12'b0111_1000_0110, 11};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 12'b0000_0000_1011, 12};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 12'b0111_1111_1110, 11};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset Tx_o", 16'(Tx_o), 16'd1);
        checkOutput("reset n_Rd_o", 16'(n_Rd_o), 16'd1);
        checkOutput("reset State_o", 16'(State_o), 16'(S_INTERVAL));
        checkOutput("reset p_Busy_o", 16'(p_Busy_o), 16'd0);
        checkOutput("reset p_ByteSent_o", 16'(p_ByteSent_o), 16'd0);
        checkOutput("reset TxByteCnt_o", TxByteCnt_o, 16'd0);
        @(negedge clk);
        rst   = 1'b0;
        monOn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            waitFrames(i + 1, 400);
            repeat (20) @(posedge clk);
            #1;
            checkOutput("byte count", TxByteCnt_o, 16'(i + 1));
            checkOutput("byte sent pulses", 16'(sentPulses), 16'(i + 1));
            checkOutput("idle state", 16'(State_o), 16'(S_INTERVAL));
            checkOutput("idle busy", 16'(p_Busy_o), 16'd0);
        end

        base = framesDone;
        rd0  = rdPulses;
        gapQ.delete();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(randVec());
        end
        waitFrames(base + 3, 1200);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("burst read pulses", 16'(rdPulses - rd0), 16'd3);
        checkOutput("burst gap count", 16'(gapQ.size()), 16'd3);
        if (gapQ.size() >= 3) begin
            checkOutput("idle bits before byte 2", 16'(gapQ[1]), 16'd0);
            checkOutput("idle bits before byte 3", 16'(gapQ[2]), 16'd0);
        end
        checkOutput("burst byte count", TxByteCnt_o, 16'd9);

        base = framesDone;
        rd0  = rdPulses;
        applyStimulus(vecs[0]);
        applyStimulus(vecs[0]);
        n = 0;
        while (State_o != S_DATABITS && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("reached DATABITS", 16'(State_o), 16'(S_DATABITS));
        p_Enable_i = 1'b0;
        waitFrames(base + 1, 400);
        repeat (640) @(posedge clk);
        #1;
        checkOutput("disabled frames", 16'(framesDone), 16'(base + 1));
        checkOutput("disabled Tx_o", 16'(Tx_o), 16'd1);
        checkOutput("disabled State_o", 16'(State_o), 16'(S_INTERVAL));
        checkOutput("disabled busy holds byte", 16'(p_Busy_o), 16'd1);
        checkOutput("disabled read pulses", 16'(rdPulses - rd0), 16'd2);
        p_Enable_i = 1'b1;
        waitFrames(base + 2, 400);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("re-enable byte count", TxByteCnt_o, 16'd11);
        checkOutput("read strobe width", 16'(rdWide), 16'd0);
        checkOutput("byte sent width", 16'(sentWide), 16'd0);

        v = vecs[0];
        v.parEn = 1'b1;
        v.frame = 12'b0101_0010_1010;
        v.len   = 11;
        applyStimulus(v);
        n = 0;
        while (State_o != S_PARITYBIT && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("reached PARITYBIT", 16'(State_o), 16'(S_PARITYBIT));
        checkOutput("even parity of A5", 16'(Tx_o), 16'd0);
        monOn = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset Tx_o", 16'(Tx_o), 16'd1);
        checkOutput("async reset State_o", 16'(State_o), 16'(S_INTERVAL));
        checkOutput("async reset count", TxByteCnt_o, 16'd0);
        checkOutput("async reset busy", 16'(p_Busy_o), 16'd0);
        expQ.delete();
        fifoQ.delete();
        rxActive   = 1'b0;
        sentPulses = 0;
        framesDone = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        monOn = 1'b1;
        applyStimulus(vecs[1]);
        waitFrames(1, 400);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("post-reset byte count", TxByteCnt_o, 16'd1);
        checkOutput("post-reset sent pulses", 16'(sentPulses), 16'd1);

`ifdef UART_TX_BREAK_EN
        begin
            logic             smp[20];
            logic [STATE_W-1:0] stAt[20];
            int               zeros;
            int               seq;
            monOn = 1'b0;
            rd0   = rdPulses;
            @(posedge clk);
            #1;
            p_Break_i = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            p_Break_i = 1'b0;
            zeros = 0;
            for (int s = 0; s < 20; s++) begin
                seq = baudSeq;
                n = 0;
                while (baudSeq == seq && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                #1;
                smp[s]  = lastSample;
                stAt[s] = State_o;
                if (lastSample == 1'b0) zeros++;
            end
            checkOutput("break low bit-times", 16'(zeros), 16'd12);
            checkOutput("break read pulses", 16'(rdPulses - rd0), 16'd0);
            for (int s = 1; s < 19; s++) begin
                if (smp[s] == 1'b1 && smp[s-1] == 1'b0) begin
                    checkOutput("break high bit state", 16'(stAt[s]), 16'(S_BREAK));
                    checkOutput("break return state", 16'(stAt[s+1]), 16'(S_INTERVAL));
                end
            end
            monOn = 1'b1;
        end
`endif

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Transmit half of the UART core. Serialises bytes pulled from the Tx FIFO onto the Tx wire: start bit, 8 data bits, optional parity bit, then 1 or 2 stop bits.
- Sits in UartCore beside the receive core. It shares the BaudSig from the baudrate generator and the parity, endianness and enable controls from CtrlCore.
- A one-byte holding register prefetches the next byte, so consecutive bytes leave back-to-back with no idle bit.

Parameters:
DATA_BITS, 8, data bits per character; the shift counter is sized from it.
BREAK_BITS, 12, bit-times Tx is held low for a break (optional feature only).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
p_Enable_i  in  1  module enable; gates new byte starts only
BaudSig_i  in  1  one-clk pulse per bit-time, from the baudrate generator
Data_i  in  8  Tx FIFO read data; valid the clk after n_Rd_o low
p_Empty_i  in  1  Tx FIFO empty
n_Rd_o  out  1  FIFO read strobe, active low, one clk wide
p_ParityEnable_i  in  1  append a parity bit
ParityMethod_i  in  1  0 = even, 1 = odd
p_BigEnd_i  in  1  1 = send bit 7 first, 0 = send bit 0 first
p_TwoStop_i  in  1  1 = two stop bits
Tx_o  out  1  serial line; idle high
State_o  out  5  one-hot FSM state
p_Busy_o  out  1  high when not in INTERVAL or the holding register is full
p_ByteSent_o  out  1  one-clk pulse at the end of the last stop bit
TxByteCnt_o  out  16  bytes sent since reset; wraps at 16'hFFFF -> 0

Behaviour:
- Reset values (asynchronous): Tx_o=1, n_Rd_o=1, State_o=INTERVAL, p_Busy_o=0, p_ByteSent_o=0, TxByteCnt_o=0, holding register empty.
- States (one-hot): INTERVAL=5'b0_0001, STARTBIT=5'b0_0010, DATABITS=5'b0_0100, PARITYBIT=5'b0_1000, STOPBIT=5'b1_0000.
- Prefetch: when the holding register is empty, p_Empty_i=0, p_Enable_i=1 and no read is outstanding, drive n_Rd_o=0 for exactly 1 clk. Capture Data_i on the next clk and mark the holding register full. At most one read is outstanding at any time.
- All state changes happen only on a clk where BaudSig_i=1. Tx_o is registered and updates on the same edge as the state.
- INTERVAL -> STARTBIT when BaudSig_i=1 and the holding register is full:
  - move holding -> shift register and free the holding register;
  - latch p_ParityEnable_i, ParityMethod_i, p_BigEnd_i, p_TwoStop_i for the whole character;
  - drive Tx_o=0.
- STARTBIT -> DATABITS on the next BaudSig_i; Tx_o = first data bit (bit 0, or bit 7 when big-end).
- DATABITS: each BaudSig_i advances one bit. After DATABITS bit-times go to PARITYBIT if parity is enabled, else STOPBIT.
- PARITYBIT drives Tx_o = ^data for even, ~^data for odd. Parity is computed from the latched byte at load time.
- STOPBIT drives Tx_o=1 for 1 or 2 bit-times. On the final BaudSig_i of STOPBIT:
  - p_ByteSent_o=1 for 1 clk and TxByteCnt_o increments;
  - if the holding register is full and p_Enable_i=1, go straight to STARTBIT (Tx_o=0, no idle bit);
  - otherwise go to INTERVAL with Tx_o=1.
- p_Enable_i low mid-character: the character completes normally; no new start and no new FIFO read. A byte already in the holding register is kept, not discarded.
- BaudSig_i coincident with the Data_i capture clk in INTERVAL: the start is deferred to the next BaudSig_i. Capture takes priority; no combinational bypass.
- p_Empty_i rising while a read is outstanding: the read still completes. The FIFO guarantees data for any read issued while non-empty.
- Latency: from the first BaudSig_i with the holding register full, Tx_o falls in the same registered edge. The byte occupies 10, 11 or 12 bit-times.

Optional Feature:
- Macro UART_TX_BREAK_EN. When defined, add input p_Break_i.
- A rising edge of p_Break_i seen in INTERVAL enters a BREAK state (5'b0_0000 is not allowed; widen State_o to 6 bits with BREAK=6'b10_0000).
- BREAK holds Tx_o=0 for BREAK_BITS BaudSig_i pulses, then 1 bit-time high, then returns to INTERVAL. No FIFO reads occur during BREAK.
- A rising edge outside INTERVAL is ignored.
- Without the macro: no port, State_o is 5 bits, and there is no break logic.

Decomposition:
- Package uart_pkg: state encodings, the PARITY_EVEN/PARITY_ODD constants, DATA_BITS default. Shared with the receive core.
- One sub-module, uart_tx_prefetch: holding register plus the read-strobe handshake (n_Rd_o, capture, full flag).

Test Plan:
1. 8'hA5, little-end, no parity, 1 stop, one BaudSig_i every 16 clk -> Tx_o sequence 0,1,0,1,0,0,1,0,1,1 at 16-clk spacing; p_ByteSent_o pulses once; TxByteCnt_o=1.
2. 8'h03, big-end, odd parity, 2 stop -> 0,0,0,0,0,0,0,1,1,1(parity),1,1; 12 bit-times.
3. FIFO holds 3 bytes, continuous -> exactly 3 single-clk n_Rd_o pulses; no idle bit between stop and next start; TxByteCnt_o=3.
4. p_Enable_i dropped during DATABITS of byte 1 of 2 -> byte 1 completes; Tx_o stays 1; the byte remains in holding; it is sent after re-enable.
5. rst asserted mid-PARITYBIT with Tx_o=0 -> Tx_o=1 and State_o=5'b0_0001 before the next clk edge; all counters cleared.
6. (UART_TX_BREAK_EN) p_Break_i pulse in INTERVAL, BREAK_BITS=12 -> Tx_o low for 12 BaudSig_i, then 1 high bit; n_Rd_o stays 1 throughout.
